serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/comparator_pkg.sv | 20 ++
 rtl/cmp_digit.sv | 24 ++
 rtl/serial_comparator.sv | 165 ++++++++++++++++
 tb/tb_serial_comparator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared definitions for the serial digit-by-digit comparator:
//   state_e          - controller states (IDLE, RUN, DONE)
//   digit_cnt_width  - width of the "digits examined" counter for given N, D
// -----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Enough bits to hold the values 0 .. N/D inclusive.
    function automatic int digit_cnt_width(input int n, input int d);
        return $clog2(n / d) + 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
// Combinational unsigned compare of one W-bit digit.
// Ports:
//   a, b  in  W  digits to compare
//   gt    out 1  a > b
//   lt    out 1  a < b
//   eq    out 1  a == b
// -----------------------------------------------------------------------------
module cmp_digit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt,
    output logic         eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
// Compares two N-bit operands one D-bit digit per cycle, most significant
// digit first, stopping at the first differing digit. Signed compares are
// done by flipping both MSBs (offset binary) so the same unsigned digit
// compare yields the two's-complement result.
// Ports:
//   clk          in  1        clock, rising edge
//   rst          in  1        synchronous active-high reset
//   start        in  1        request; accepted when ready=1
//   ready        out 1        idle, able to accept start
//   a, b         in  N        operands, sampled on accept
//   signed_mode  in  1        1 = two's complement, 0 = unsigned
//   done         out 1        one-cycle pulse, result valid
//   gt, lt, eq   out 1 each   A>B, A<B, A==B (held until next result)
//   digits       out CW       digits examined by the last operation
// -----------------------------------------------------------------------------
module serial_comparator
    import comparator_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int D  = 2,
    localparam int CW = digit_cnt_width(N, D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          signed_mode,
    output logic          done,
    output logic          gt,
    output logic          lt,
    output logic          eq,
    output logic [CW-1:0] digits
);

    localparam int NDIG = N / D;

    state_e        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [CW-1:0] idx_q, idx_d;       // digits already found equal
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic [CW-1:0] digits_q, digits_d;

    logic          accept;
    logic          dig_gt, dig_lt, dig_eq;
    logic [N-1:0]  msb_flip;

    assign accept   = (state_q == IDLE) && start;
    assign msb_flip = N'(signed_mode) << (N - 1);

    // The single digit comparator always looks at the top digit of the
    // shift registers; shifting left brings the next digit into place.
    cmp_digit #(.W(D)) u_cmp_digit (
        .a  (a_sh_q[N-1 -: D]),
        .b  (b_sh_q[N-1 -: D]),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    // ---------------------------------------------------------------------
    // State / result registers
    // ---------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            digits_q <= digits_d;
        end
    end

    // NOTE: the operand shift registers have no reset; they are always
    // loaded on accept before the controller ever reads them.
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold default first so no path through
        // this block can infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        digits_d = digits_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sh_d  = a ^ msb_flip;
                    b_sh_d  = b ^ msb_flip;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!dig_eq) begin
                    // First differing digit decides the result.
                    gt_d     = dig_gt;
                    lt_d     = dig_lt;
                    eq_d     = 1'b0;
                    digits_d = idx_q + CW'(1);
                    state_d  = DONE;
                end else if (idx_q == CW'(NDIG - 1)) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    digits_d = CW'(NDIG);
                    state_d  = DONE;
                end else begin
                    a_sh_d = a_sh_q << D;
                    b_sh_d = b_sh_q << D;
                    idx_d  = idx_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        ready  = (state_q == IDLE);
        done   = (state_q == DONE);
        gt     = gt_q;
        lt     = lt_q;
        eq     = eq_q;
        digits = digits_q;
    end

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
// Drives three comparator instances (N=8/D=2, N=4/D=1, N=4/D=4) and checks
// them against an arithmetic reference compare.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Per-instance stimulus and observed outputs: 0 = N8D2, 1 = N4D1, 2 = N4D4
    logic       start_v [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic       mode_v  [3];
    logic       ready_v [3];
    logic       done_v  [3];
    logic       gt_v    [3];
    logic       lt_v    [3];
    logic       eq_v    [3];
    logic [3:0] dig_v   [3];

    logic [2:0] dig0;
    logic [2:0] dig1;
    logic [0:0] dig2;

    assign dig_v[0] = {1'b0, dig0};
    assign dig_v[1] = {1'b0, dig1};
    assign dig_v[2] = {3'b000, dig2};

    serial_comparator #(.N(8), .D(2)) u_main (
        .clk(clk), .rst(rst), .start(start_v[0]), .ready(ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .signed_mode(mode_v[0]), .done(done_v[0]),
        .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .digits(dig0)
    );

    serial_comparator #(.N(4), .D(1)) u_n4d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .ready(ready_v[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .signed_mode(mode_v[1]), .done(done_v[1]),
        .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .digits(dig1)
    );

    serial_comparator #(.N(4), .D(4)) u_n4d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .ready(ready_v[2]),
        .a(a_v[2][3:0]), .b(b_v[2][3:0]), .signed_mode(mode_v[2]), .done(done_v[2]),
        .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .digits(dig2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer compare of the interpreted values; digit count is
    // the 1-based position (from the MSB end) of the first differing digit.
    function automatic void ref_cmp(input int a, input int b, input bit m,
                                    input int n, input int d,
                                    output int gt, output int lt,
                                    output int eq, output int k);
        int  sa, sb, nd, da, db;
        bit  found;
        sa = a;
        sb = b;
        if (m) begin
            if (a >= (1 << (n - 1))) sa = a - (1 << n);
            if (b >= (1 << (n - 1))) sb = b - (1 << n);
        end
        gt = (sa > sb) ? 1 : 0;
        lt = (sa < sb) ? 1 : 0;
        eq = (sa == sb) ? 1 : 0;
        nd = n / d;
        k = nd;
        found = 1'b0;
        for (int i = 0; i < nd; i++) begin
            da = (a >> (n - d * (i + 1))) % (1 << d);
            db = (b >> (n - d * (i + 1))) % (1 << d);
            if (!found && da != db) begin
                k = i + 1;
                found = 1'b1;
            end
        end
    endfunction

    // One isolated operation on instance sel. Inputs are scrambled after
    // accept and a stray start is raised while busy; neither may matter.
    task automatic run_op(input int sel, input int a, input int b, input bit m,
                          input int n, input int d, input string tag);
        int gt, lt, eq, k, lat;
        bit seen;
        ref_cmp(a, b, m, n, d, gt, lt, eq, k);
        @(negedge clk);
        check({tag, "_ready_before"}, ready_v[sel], 1);
        a_v[sel]     = 8'(a);
        b_v[sel]     = 8'(b);
        mode_v[sel]  = m;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        a_v[sel]     = ~a_v[sel];
        b_v[sel]     = 8'(a);
        mode_v[sel]  = ~m;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            start_v[sel] = (lat == 0);
            if (done_v[sel]) seen = 1'b1;
            else lat++;
        end
        start_v[sel] = 1'b0;
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, lat, k);
            check({tag, "_gt"}, gt_v[sel], gt);
            check({tag, "_lt"}, lt_v[sel], lt);
            check({tag, "_eq"}, eq_v[sel], eq);
            check({tag, "_digits"}, dig_v[sel], k);
            @(negedge clk);
            check({tag, "_done_width"}, done_v[sel], 0);
            check({tag, "_ready_after"}, ready_v[sel], 1);
        end
    endtask

    initial begin
        int e_gt, e_lt, e_eq, e_k, done_edge, nxt, done_cnt;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            mode_v[i]  = 1'b0;
        end

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), ready_v[i], 1);
            check($sformatf("rst_done%0d", i), done_v[i], 0);
            check($sformatf("rst_flags%0d", i), {gt_v[i], lt_v[i], eq_v[i]}, 0);
            check($sformatf("rst_digits%0d", i), dig_v[i], 0);
        end
        rst = 1'b0;

        // ---------------- directed cases, N=8 D=2 ----------------
        run_op(0, 8'h80, 8'h7F, 1'b0, 8, 2, "u_80_7f");
        run_op(0, 8'h80, 8'h7F, 1'b1, 8, 2, "s_80_7f");
        run_op(0, 8'h5A, 8'h5A, 1'b0, 8, 2, "u_eq_5a");
        run_op(0, 8'h5A, 8'h5A, 1'b1, 8, 2, "s_eq_5a");
        run_op(0, 8'h01, 8'h00, 1'b0, 8, 2, "u_01_00");
        run_op(0, 8'hFF, 8'h01, 1'b1, 8, 2, "s_ff_01");
        run_op(0, 8'h00, 8'hFF, 1'b0, 8, 2, "u_00_ff");

        // ---------------- random isolated ops ----------------
        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? (ra ^ (1 << $urandom_range(0, 7)))
                                              : int'($urandom_range(0, 255));
            run_op(0, ra, rb, 1'($urandom_range(0, 1)), 8, 2, "rand");
        end

        // ---------------- back-to-back, start held high ----------------
        done_edge = -1;
        nxt       = 0;
        e_gt = 0; e_lt = 0; e_eq = 0; e_k = 0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (e > 0) begin
                check("b2b_done", done_v[0], ((e - 1) == done_edge) ? 1 : 0);
                if ((e - 1) == done_edge) begin
                    check("b2b_gt", gt_v[0], e_gt);
                    check("b2b_lt", lt_v[0], e_lt);
                    check("b2b_eq", eq_v[0], e_eq);
                    check("b2b_digits", dig_v[0], e_k);
                end
            end
            check("b2b_ready", ready_v[0], (e == nxt) ? 1 : 0);
            a_v[0]     = 8'($urandom_range(0, 255));
            b_v[0]     = ($urandom_range(0, 2) == 0) ? a_v[0] : 8'($urandom_range(0, 255));
            mode_v[0]  = 1'($urandom_range(0, 1));
            start_v[0] = 1'b1;
            @(posedge clk);
            if (e == nxt) begin
                ref_cmp(int'(a_v[0]), int'(b_v[0]), mode_v[0], 8, 2, e_gt, e_lt, e_eq, e_k);
                done_edge = e + e_k;
                nxt       = e + e_k + 2;
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);

        // ---------------- reset during second RUN cycle ----------------
        check("abort_ready_before", ready_v[0], 1);
        a_v[0] = 8'h33; b_v[0] = 8'h33; mode_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(negedge clk);          // first RUN cycle
        @(negedge clk);          // second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", done_v[0], 0);
        check("abort_flags", {gt_v[0], lt_v[0], eq_v[0]}, 0);
        check("abort_digits", dig_v[0], 0);
        check("abort_ready", ready_v[0], 1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v[0]) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // ---------------- exhaustive N=4: D=1 and D=4 ----------------
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op(1, x, y, 1'(m), 4, 1, "n4d1");
                    run_op(2, x, y, 1'(m), 4, 4, "n4d4");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
